// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed 7-segment scan driver with frame-synchronous message updates
// Blink and anti-ghosting blank gap are included; every output is a register.
module seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_GAP   = 2,
    parameter int BLINK_DIV   = 50
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [5*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [4:0]              num,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    load_ack,
    output logic                    frame_tick
);

    localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SW-1:0] LAST_SLOT  = SW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] LAST_BLINK = BW'(BLINK_DIV - 1);
    localparam logic [4:0]    CODE_BLANK = 5'd31;

    logic [SW-1:0]             slot_cnt_q, slot_cnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [BW-1:0]             blink_cnt_q, blink_cnt_d;
    logic                      blink_phase_q, blink_phase_d;
    logic                      pending_q, pending_d;
    logic [5*NUM_DIGITS-1:0]   staging_q, staging_d;
    logic [5*NUM_DIGITS-1:0]   shadow_q, shadow_d;
    logic [4:0]                num_q, num_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic                      load_ack_q, load_ack_d;
    logic                      frame_tick_q, frame_tick_d;

    logic slot_wrap;
    logic frame_end;
    logic lit;

    always_comb begin
        slot_cnt_d    = slot_cnt_q;
        idx_d         = idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        pending_d     = pending_q;
        staging_d     = staging_q;
        shadow_d      = shadow_q;
        an_d          = '1;
        num_d         = CODE_BLANK;

        slot_wrap = enable && (slot_cnt_q == LAST_SLOT);
        frame_end = slot_wrap && (idx_q == LAST_IDX);

        if (enable) begin
            slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + SW'(1);
        end
        if (slot_wrap) begin
            idx_d = frame_end ? '0 : idx_q + IW'(1);
        end

        if (frame_end) begin
            if (blink_cnt_q == LAST_BLINK) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end

        if (load) begin
            staging_d = digits_in;
            pending_d = 1'b1;
        end
        // A load landing on the boundary itself goes straight to the shadow.
        if (frame_end) begin
            if (load) begin
                shadow_d = digits_in;
            end else if (pending_q) begin
                shadow_d = staging_q;
            end
            pending_d = 1'b0;
        end

        load_ack_d   = frame_end && (load || pending_q);
        frame_tick_d = frame_end;

        lit = enable && (int'(slot_cnt_q) >= BLANK_GAP);
        if (lit) begin
            an_d[idx_q] = 1'b0;
            if (!(blink_mask[idx_q] && blink_phase_q)) begin
                num_d = shadow_q[5*int'(idx_q) +: 5];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q    <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            pending_q     <= 1'b0;
            staging_q     <= {NUM_DIGITS{CODE_BLANK}};
            shadow_q      <= {NUM_DIGITS{CODE_BLANK}};
            num_q         <= CODE_BLANK;
            an_q          <= '1;
            load_ack_q    <= 1'b0;
            frame_tick_q  <= 1'b0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            pending_q     <= pending_d;
            staging_q     <= staging_d;
            shadow_q      <= shadow_d;
            num_q         <= num_d;
            an_q          <= an_d;
            load_ack_q    <= load_ack_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign num        = num_q;
    assign an         = an_q;
    assign load_ack   = load_ack_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed table-driven bench for seg_scan_driver
// Four digits, four cycles per slot, one gap cycle, blink toggles every two frames.
module tb_seg_scan_driver;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [19:0] digits_in;
    logic        load;
    logic [3:0]  blink_mask;
    logic [4:0]  num;
    logic [3:0]  an;
    logic        load_ack;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    seg_scan_driver #(
        .NUM_DIGITS (4),
        .REFRESH_DIV(4),
        .BLANK_GAP  (1),
        .BLINK_DIV  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .digits_in (digits_in),
        .load      (load),
        .blink_mask(blink_mask),
        .num       (num),
        .an        (an),
        .load_ack  (load_ack),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [19:0] BLANK = {4{5'd31}};
    localparam logic [19:0] VA    = {5'd16, 5'd17, 5'd10, 5'd13};
    localparam logic [19:0] VA_BL = {5'd16, 5'd17, 5'd10, 5'd31};
    localparam logic [19:0] VB    = {5'd1,  5'd2,  5'd3,  5'd4};
    localparam logic [19:0] VC    = {5'd5,  5'd6,  5'd7,  5'd8};
    localparam logic [19:0] VD    = {5'd9,  5'd9,  5'd9,  5'd9};
    localparam logic [19:0] VE    = {5'd0,  5'd11, 5'd12, 5'd14};
    localparam logic [19:0] VF    = {5'd21, 5'd22, 5'd23, 5'd24};
    localparam logic [19:0] VG    = {5'd25, 5'd26, 5'd27, 5'd28};

    typedef struct {
        logic [3:0]  mask;
        int          ld1_k;
        logic [19:0] ld1_v;
        int          ld2_k;
        logic [19:0] ld2_v;
        logic [19:0] codes;
        logic        ack;
    } frame_vec_t;

    frame_vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " an"}, 32'(an), 32'hF);
        chk({tag, " num"}, 32'(num), 32'd31);
        chk({tag, " frame_tick"}, 32'(frame_tick), 32'd0);
        chk({tag, " load_ack"}, 32'(load_ack), 32'd0);
    endtask

    // Frame position k = 1..16 names the clock edge; the state before edge k
    // is slot (k-1)%4 of digit (k-1)/4, and edge 16 is the frame boundary.
    task automatic run_cycles(input string tag, input int k0, input int k1,
                              input logic [19:0] codes,
                              input int l1k, input logic [19:0] l1v,
                              input int l2k, input logic [19:0] l2v,
                              input logic ack);
        int s;
        int d;
        logic [3:0] e_an;
        logic [4:0] e_num;
        for (int k = k0; k <= k1; k++) begin
            load      = (k == l1k) || (k == l2k);
            digits_in = (k == l2k) ? l2v : l1v;
            @(posedge clk);
            #1;
            load = 1'b0;
            s = (k - 1) % 4;
            d = (k - 1) / 4;
            e_an  = (s == 0) ? 4'hF : ~(4'b0001 << d);
            e_num = (s == 0) ? 5'd31 : codes[5*d +: 5];
            chk($sformatf("%s k%0d an", tag, k), 32'(an), 32'(e_an));
            chk($sformatf("%s k%0d num", tag, k), 32'(num), 32'(e_num));
            chk($sformatf("%s k%0d frame_tick", tag, k), 32'(frame_tick), 32'(k == 16));
            chk($sformatf("%s k%0d load_ack", tag, k), 32'(load_ack), 32'((k == 16) && ack));
        end
    endtask

    initial begin
        tbl[0]  = '{4'h0, 0,  BLANK, 0, BLANK, BLANK, 1'b0};
        tbl[1]  = '{4'h0, 5,  VA,    0, BLANK, BLANK, 1'b1};
        tbl[2]  = '{4'h0, 0,  BLANK, 0, BLANK, VA,    1'b0};
        tbl[3]  = '{4'h0, 0,  BLANK, 0, BLANK, VA,    1'b0};
        tbl[4]  = '{4'h1, 0,  BLANK, 0, BLANK, VA,    1'b0};
        tbl[5]  = '{4'h1, 0,  BLANK, 0, BLANK, VA,    1'b0};
        tbl[6]  = '{4'h1, 0,  BLANK, 0, BLANK, VA_BL, 1'b0};
        tbl[7]  = '{4'h1, 0,  BLANK, 0, BLANK, VA_BL, 1'b0};
        tbl[8]  = '{4'h0, 16, VB,    0, BLANK, VA,    1'b1};
        tbl[9]  = '{4'h0, 3,  VC,    0, BLANK, VB,    1'b1};
        tbl[10] = '{4'h0, 2,  VD,    9, VE,    VC,    1'b1};
        tbl[11] = '{4'h0, 0,  BLANK, 0, BLANK, VE,    1'b0};

        rst_n      = 1'b0;
        enable     = 1'b0;
        load       = 1'b0;
        digits_in  = '0;
        blink_mask = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        rst_n  = 1'b1;
        enable = 1'b1;

        for (int i = 0; i < 12; i++) begin
            blink_mask = tbl[i].mask;
            run_cycles($sformatf("frame%0d", i), 1, 16, tbl[i].codes,
                       tbl[i].ld1_k, tbl[i].ld1_v, tbl[i].ld2_k, tbl[i].ld2_v, tbl[i].ack);
        end
        blink_mask = '0;

        // Pause mid-slot with a load inside the dark window.
        run_cycles("pre_pause", 1, 2, VE, 0, BLANK, 0, BLANK, 1'b0);
        enable = 1'b0;
        for (int j = 0; j < 10; j++) begin
            load      = (j == 2);
            digits_in = VF;
            @(posedge clk);
            #1;
            load = 1'b0;
            chk_idle($sformatf("paused%0d", j));
        end
        enable = 1'b1;
        run_cycles("resume", 3, 16, VE, 0, BLANK, 0, BLANK, 1'b1);
        run_cycles("after_resume", 1, 16, VF, 0, BLANK, 0, BLANK, 1'b0);

        // Asynchronous reset between edges while a load is pending.
        run_cycles("pre_reset", 1, 6, VF, 3, VG, 0, BLANK, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async_reset");
        repeat (2) @(posedge clk);
        #1;
        chk_idle("held_reset");
        rst_n = 1'b1;
        run_cycles("post_reset0", 1, 16, BLANK, 0, BLANK, 0, BLANK, 1'b0);
        run_cycles("post_reset1", 1, 16, BLANK, 0, BLANK, 0, BLANK, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Time-multiplexes NUM_DIGITS 5-bit display codes onto a shared 7-segment bus and drives the active-low digit anodes. It sits directly upstream of the code-to-segment converter: `num` feeds the converter's `num` input, and `an` goes to the board/Pmod anodes. It also provides tear-free frame-synchronous updates of the displayed message, per-digit blinking and an anti-ghosting blank gap.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 100000, clk cycles per digit slot (>= BLANK_GAP+1)
BLANK_GAP, 2, cycles at the start of each slot with all anodes off (0 allowed)
BLINK_DIV, 50, frames per blink half-period (>= 1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous assert, active-low
enable  in  1  1 = scan runs; 0 = display dark, all counters hold
digits_in  in  5*NUM_DIGITS  requested codes; digit k at bits [5k+4:5k]; digit 0 is leftmost
load  in  1  one-cycle strobe; captures digits_in for display from the next frame boundary
blink_mask  in  NUM_DIGITS  bit k = 1 blinks digit k
num  out  5  code of the currently lit digit, to the converter; 31 = blank
an  out  NUM_DIGITS  active-low anode enables; at most one bit low
load_ack  out  1  one-cycle pulse when the staged codes become visible
frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (async, rst_n=0) values:
  - slot_cnt=0, idx=0, blink_cnt=0, blink_phase=0, pending=0.
  - staging and shadow all 31.
  - num=31, an=all 1, load_ack=0, frame_tick=0.
- All outputs are driven from registers; there is no combinational input-to-output path.
- Slot counter:
  - When enable=1, slot_cnt counts 0..REFRESH_DIV-1 and then wraps.
  - On wrap, idx advances and wraps from NUM_DIGITS-1 to 0.
- Frame boundary: the cycle in which slot_cnt wraps and idx goes from NUM_DIGITS-1 to 0.
  - frame_tick=1 in that cycle and is registered, so it is visible the following cycle.
- Blink:
  - blink_cnt counts frame boundaries 0..BLINK_DIV-1.
  - On wrap, blink_phase toggles.
- Outputs for the current registered state:
  - an: if enable=0 or slot_cnt<BLANK_GAP, all 1. Otherwise bit idx=0 and the rest 1.
  - num: 31 whenever an is all 1. Otherwise 31 if blink_mask[idx] && blink_phase. Otherwise shadow[idx].
  - Both are registered one cycle behind the counters and remain mutually consistent; the latency is constant.
- Load handshake:
  - load=1 copies digits_in into staging and sets pending=1.
  - Repeated loads before a boundary: the last one wins, and a single ack is issued.
  - At a frame boundary with pending=1: shadow <= staging, pending <= 0, load_ack pulses for 1 cycle, aligned with frame_tick.
  - load coincident with a boundary: digits_in bypasses directly into shadow, pending ends at 0, and load_ack pulses.
  - No boundary and no pending: shadow holds.
- enable=0:
  - Counters, idx, blink state and shadow are frozen.
  - load still captures into staging, and pending persists until a boundary occurs after enable returns.
- Reset mid-frame or mid-pending discards staging; no load_ack is issued afterwards.
- blink_mask is sampled live and takes effect within the next output update; it is not frame-synchronised.
- Width rule: slot_cnt is clog2(REFRESH_DIV) bits, idx is clog2(NUM_DIGITS) bits, blink_cnt is clog2(BLINK_DIV) bits. Counters never exceed their limits.

Test Plan:
(Test parameters: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_GAP=1, BLINK_DIV=2.)
1. Reset then enable=1, no load -> an sequence per slot is 1111 for 1 cycle, then 1110 for 3 cycles, then 1111/1101, 1111/1011, 1111/0111. num=31 throughout; frame_tick every 16 cycles.
2. load with digits_in={16,17,10,13} (digits 3..0) mid-frame -> shadow unchanged until the boundary. load_ack coincides with frame_tick. The next frame shows num=13,10,17,16 while the corresponding an bit is low, and 31 during gaps.
3. load asserted exactly on the boundary cycle, then a second load 3 cycles later with different data -> the first data is visible immediately with one ack. The second data appears at the next boundary with a second ack.
4. blink_mask=0001 with codes loaded -> digit 0 num alternates 13 for 2 frames, then 31 for 2 frames. Other digits remain steady; an timing is unchanged.
5. enable=0 mid-slot for 10 cycles, with a load during that window -> an=1111 and num=31. Counters resume from the frozen values, and load_ack arrives at the first boundary after re-enable.
6. rst_n pulsed low asynchronously, between clock edges, while pending=1 -> outputs immediately go to their reset values. No load_ack follows, and shadow is all 31.
